// File: rtl/dispense_pkg.sv
// dispense_pkg: state codes and widths shared by the dispense sequencer.
// Codes match the legacy three-motor loader's `est` encoding.
package dispense_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        LECTURA = 3'b000,
        ESPERA  = 3'b001,
        CARGA   = 3'b011,
        FIN     = 3'b100,
        ERROR   = 3'b101
    } state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dispense_next_ch.sv
// dispense_next_ch: finds the highest set bit of `mask` strictly below `cur`.
// `none` is raised when no such bit exists.
module dispense_next_ch
    import dispense_pkg::*;
#(
    parameter int N_CH = 3,
    localparam int IW = idx_w(N_CH),
    localparam int CW = $clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CW-1:0]   cur,
    output logic [IW-1:0]   nxt,
    output logic            none
);

    // Ascending scan: the last qualifying bit wins, i.e. the highest one.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (mask[i] && (i < int'(cur))) begin
                nxt  = IW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dispense_seq.sv
// dispense_seq: N_CH-channel paint-dispense sequencer, highest channel first.
// Optional per-channel timeout with ERROR state under DISPENSE_TIMEOUT_EN.
module dispense_seq
    import dispense_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int TIMEOUT_CYC = 50000,
    localparam int IW = idx_w(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RGB_full,
    input  logic            enter,
    input  logic            abort,
    input  logic [N_CH-1:0] ch_en,
    input  logic [N_CH-1:0] flags,
    output logic [N_CH-1:0] Motores,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [IW-1:0]   ch_idx,
    output logic [ST_W-1:0] est
);

    localparam int CW = $clog2(N_CH + 1);

    state_e          state_q;
    state_e          state_d;
    logic [N_CH-1:0] mask_q;
    logic [N_CH-1:0] mask_d;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;

    logic [IW-1:0]   start_idx;
    logic            start_none;
    logic [IW-1:0]   adv_idx;
    logic            adv_none;

    logic [N_CH-1:0] onehot;
    logic            flag_hit;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic          expired;

    assign expired = (cnt_q == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_cfg;

    assign unused_cfg = ^32'(TIMEOUT_CYC);
`endif

    // First channel of a new job comes straight from the live ch_en.
    dispense_next_ch #(
        .N_CH (N_CH)
    ) u_start (
        .mask (ch_en),
        .cur  (CW'(N_CH)),
        .nxt  (start_idx),
        .none (start_none)
    );

    // Next channel after the active one, from the latched job mask.
    dispense_next_ch #(
        .N_CH (N_CH)
    ) u_adv (
        .mask (mask_q),
        .cur  (CW'(idx_q)),
        .nxt  (adv_idx),
        .none (adv_none)
    );

    assign onehot   = N_CH'(1) << idx_q;
    assign flag_hit = |(flags & onehot);

    // Next-state and datapath updates; abort beats flag beats timeout.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
`ifdef DISPENSE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            LECTURA: begin
                if (RGB_full) begin
                    state_d = ESPERA;
                end
            end
            ESPERA: begin
                if (!RGB_full) begin
                    state_d = LECTURA;
                end else if (enter) begin
                    mask_d = ch_en;
                    if (start_none) begin
                        state_d = FIN;
                    end else begin
                        state_d = CARGA;
                        idx_d   = start_idx;
`ifdef DISPENSE_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            CARGA: begin
                if (abort) begin
                    state_d = LECTURA;
                end else if (flag_hit) begin
                    if (adv_none) begin
                        state_d = FIN;
                    end else begin
                        idx_d = adv_idx;
`ifdef DISPENSE_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end
`ifdef DISPENSE_TIMEOUT_EN
                end else if (expired) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + TW'(1);
`endif
                end
            end
            FIN: begin
                state_d = LECTURA;
            end
`ifdef DISPENSE_TIMEOUT_EN
            ERROR: begin
                if (abort) begin
                    state_d = LECTURA;
                end
            end
`endif
            default: begin
                state_d = LECTURA;
            end
        endcase
    end

    // State, job mask and active channel registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LECTURA;
            mask_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
        end
    end

`ifdef DISPENSE_TIMEOUT_EN
    // Per-channel cycle counter for the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign busy    = (state_q == CARGA);
    assign done    = (state_q == FIN);
    assign Motores = busy ? onehot : '0;
    assign ch_idx  = busy ? idx_q : '0;
    assign est     = state_q;

`ifdef DISPENSE_TIMEOUT_EN
    assign error = (state_q == ERROR);
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_seq.sv
// tb_dispense_seq: scoreboard bench for dispense_seq against a job-level
// model (queue of pending channels, cycle timer).
module tb_dispense_seq;

    localparam int N_CH = 3;
    localparam int TO   = 8;
    localparam int IW   = $clog2(N_CH);
`ifdef DISPENSE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            RGB_full = 1'b0;
    logic            enter = 1'b0;
    logic            abort = 1'b0;
    logic [N_CH-1:0] ch_en = '0;
    logic [N_CH-1:0] flags = '0;
    logic [N_CH-1:0] Motores;
    logic            busy;
    logic            done;
    logic            error;
    logic [IW-1:0]   ch_idx;
    logic [2:0]      est;

    dispense_seq #(
        .N_CH        (N_CH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RGB_full (RGB_full),
        .enter    (enter),
        .abort    (abort),
        .ch_en    (ch_en),
        .flags    (flags),
        .Motores  (Motores),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .ch_idx   (ch_idx),
        .est      (est)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mot;
        int dn;
        int er;
        int bz;
        int st;
        int ix;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Model: mode holds the expected est code; chq lists pending channels.
    int m_mode = 0;
    int m_chq[$];
    int m_tmr = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    endtask

    function automatic exp_t m_out();
        exp_t e;
        e.bz  = (m_mode == 3) ? 1 : 0;
        e.dn  = (m_mode == 4) ? 1 : 0;
        e.er  = (m_mode == 5) ? 1 : 0;
        e.st  = m_mode;
        e.ix  = e.bz ? m_chq[0] : 0;
        e.mot = e.bz ? (1 << m_chq[0]) : 0;
        return e;
    endfunction

    task automatic m_reset();
        m_mode = 0;
        m_chq.delete();
        m_tmr = 0;
    endtask

    task automatic m_step(input logic rgb, input logic ent, input logic ab,
                          input logic [N_CH-1:0] cen, input logic [N_CH-1:0] fl);
        case (m_mode)
            0: if (rgb) m_mode = 1;
            1: begin
                if (!rgb) m_mode = 0;
                else if (ent) begin
                    m_chq.delete();
                    for (int c = N_CH - 1; c >= 0; c--)
                        if (cen[c]) m_chq.push_back(c);
                    if (m_chq.size() == 0) m_mode = 4;
                    else begin
                        m_mode = 3;
                        m_tmr = 0;
                    end
                end
            end
            3: begin
                if (ab) begin
                    m_mode = 0;
                    m_chq.delete();
                end else if (fl[m_chq[0]]) begin
                    void'(m_chq.pop_front());
                    if (m_chq.size() == 0) m_mode = 4;
                    else m_tmr = 0;
                end else if (TO_EN && m_tmr == TO - 1) begin
                    m_mode = 5;
                end else begin
                    m_tmr++;
                end
            end
            4: m_mode = 0;
            5: if (ab) m_mode = 0;
            default: m_mode = 0;
        endcase
    endtask

    // Monitor: outputs are sampled mid-cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("Motores", int'(Motores), e.mot);
            chk("done", int'(done), e.dn);
            chk("error", int'(error), e.er);
            chk("busy", int'(busy), e.bz);
            chk("est", int'(est), e.st);
            chk("ch_idx", int'(ch_idx), e.ix);
        end
    end

    task automatic drive(input logic rgb, input logic ent, input logic ab,
                         input logic [N_CH-1:0] cen, input logic [N_CH-1:0] fl);
        RGB_full = rgb;
        enter    = ent;
        abort    = ab;
        ch_en    = cen;
        flags    = fl;
    endtask

    task automatic cyc(input logic rgb, input logic ent, input logic ab,
                       input logic [N_CH-1:0] cen, input logic [N_CH-1:0] fl);
        @(posedge clk);
        #1;
        sbq.push_back(m_out());
        reset = 1'b1;
        drive(rgb, ent, ab, cen, fl);
        m_step(rgb, ent, ab, cen, fl);
    endtask

    task automatic hold_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            m_reset();
            sbq.push_back(m_out());
            drive(1'b0, 1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic mid_reset();
        exp_t e;
        @(posedge clk);
        #1;
        e = m_out();
        chk("pre_reset_motor", int'(Motores), e.mot);
        #1;
        reset = 1'b0;
        #1;
        chk("async_clear", int'(Motores), 0);
        m_reset();
        sbq.push_back(m_out());
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        m_reset();
        #1 reset = 1'b0;
        hold_reset(3);

        // full job R, Y, B
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 1, 0, 3'b111, 3'b000);
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 0, 0, 3'b000, 3'b100);
        cyc(1, 0, 0, 3'b000, 3'b001);
        cyc(1, 0, 0, 3'b000, 3'b010);
        cyc(1, 0, 0, 3'b000, 3'b001);
        idle(2);

        // skip channel 1; its flag and late ch_en changes are ignored
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 1, 0, 3'b101, 3'b000);
        cyc(1, 0, 0, 3'b000, 3'b010);
        cyc(1, 0, 0, 3'b010, 3'b100);
        cyc(1, 0, 0, 3'b000, 3'b010);
        cyc(1, 0, 0, 3'b000, 3'b001);
        idle(2);

        // empty mask
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 1, 0, 3'b000, 3'b000);
        idle(3);

        // abort together with active flag
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 1, 0, 3'b111, 3'b000);
        cyc(1, 0, 1, 3'b000, 3'b100);
        idle(2);

        // flag lands on the last allowed cycle
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 1, 0, 3'b100, 3'b000);
        for (int k = 0; k < TO - 1; k++) cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 0, 0, 3'b000, 3'b100);
        idle(2);

        // no flags at all, then abort
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 1, 0, 3'b011, 3'b000);
        for (int k = 0; k < TO + 4; k++) cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 0, 1, 3'b000, 3'b000);
        idle(2);

        // RGB_full drops with enter
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(0, 1, 0, 3'b111, 3'b000);
        idle(2);

        // reset mid-job
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(1, 1, 0, 3'b110, 3'b000);
        cyc(1, 0, 0, 3'b000, 3'b000);
        mid_reset();
        idle(2);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            logic            r;
            logic            e;
            logic            a;
            logic [N_CH-1:0] c;
            logic [N_CH-1:0] f;
            r = ($urandom_range(0, 99) < 85);
            e = ($urandom_range(0, 99) < 30);
            a = ($urandom_range(0, 99) < 4);
            c = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            f = ($urandom_range(0, 99) < 35) ?
                N_CH'($urandom_range(0, (1 << N_CH) - 1)) : '0;
            cyc(r, e, a, c, f);
        end

        repeat (3) @(negedge clk);
        #1;
        chk("drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
